// File: rtl/spot_pkg.sv
// spot_pkg
//   Shared constants for the multi-channel button conditioner (multi_spot).
//   EDGE_* select which debounced edge produces a pulse. DEFAULT_* hold the
//   default synchroniser depth and debounce length. select_edge() turns a
//   rise/fall pair into the pulse for a given edge mode.
//   Optional feature macro used by the blocks importing this package:
//   MULTI_SPOT_AUTOREPEAT_EN (hold-to-repeat).
package spot_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_DB_CYCLES   = 4;

    function automatic logic select_edge(input int mode, input logic rise, input logic fall);
        logic pulse;
        case (mode)
            EDGE_RISE: pulse = rise;
            EDGE_FALL: pulse = fall;
            EDGE_BOTH: pulse = rise | fall;
            default:   pulse = 1'b0;
        endcase
        return pulse;
    endfunction

endpackage

// File: rtl/spot_debounce_ch.sv
// spot_debounce_ch
//   One channel of multi_spot: synchroniser, stable-count debounce filter,
//   debounced level and delayed-level registers, edge pulse selection and,
//   with MULTI_SPOT_AUTOREPEAT_EN defined, a hold-to-repeat counter.
//   Ports:
//     clk       in   system clock
//     rst       in   asynchronous active-high reset
//     spot_in   in   raw asynchronous button/switch input
//     level_out out  debounced, synchronised level
//     spot_out  out  one-clock pulse per qualifying debounced edge
//                    (plus repeat pulses while held, if enabled)
module spot_debounce_ch
    import spot_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter int EDGE_MODE   = EDGE_RISE
`ifdef MULTI_SPOT_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic spot_in,
    output logic level_out,
    output logic spot_out
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          db_cnt;
    logic                   lvl_d;
    logic                   edge_pulse;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], spot_in};
        end
    end

    // The counter only runs while the synchronised input disagrees with the
    // debounced level; any agreement restarts it, so short glitches never
    // reach the terminal count. Clearing at the terminal count keeps it
    // from ever wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt    <= '0;
            level_out <= 1'b0;
            lvl_d     <= 1'b0;
        end else begin
            lvl_d <= level_out;
            if (s == level_out) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                level_out <= s;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

    assign edge_pulse = select_edge(EDGE_MODE, level_out & ~lvl_d, ~level_out & lvl_d);

`ifdef MULTI_SPOT_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_pulse;

    // The counter is 0 on the rise-pulse cycle. The repeat pulse is
    // registered so it lands on the cycle where the counter has wrapped to
    // 0, i.e. exactly REPEAT_CYCLES clocks after the previous pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_pulse <= 1'b0;
        end else if (!level_out) begin
            rpt_cnt   <= '0;
            rpt_pulse <= 1'b0;
        end else if (rpt_cnt == RPT_LAST) begin
            rpt_cnt   <= '0;
            rpt_pulse <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + RW'(1);
            rpt_pulse <= 1'b0;
        end
    end

    // Gating with the level stops a repeat armed on the release edge from
    // leaking out after the button has gone.
    assign spot_out = edge_pulse | (rpt_pulse & level_out);
`else
    assign spot_out = edge_pulse;
`endif

endmodule

// File: rtl/multi_spot.sv
// multi_spot
//   Multi-channel button/switch conditioner: each channel synchronises,
//   debounces and edge-detects its own input independently.
//   Optional feature: define MULTI_SPOT_AUTOREPEAT_EN for hold-to-repeat
//   pulses every REPEAT_CYCLES clocks while a channel's level is high.
//   Ports:
//     clk       in   system clock
//     rst       in   asynchronous active-high reset
//     spot_in   in   [N_CH] raw asynchronous inputs
//     level_out out  [N_CH] debounced, synchronised levels
//     spot_out  out  [N_CH] one-clock pulses per qualifying debounced edge
module multi_spot
    import spot_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int DB_CYCLES     = DEFAULT_DB_CYCLES,
    parameter int EDGE_MODE     = EDGE_RISE,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] spot_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] spot_out
);

    if (N_CH < 1) begin : g_bad_n_ch
        $error("multi_spot: N_CH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("multi_spot: SYNC_STAGES must be >= 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("multi_spot: DB_CYCLES must be >= 1");
    end
    if (EDGE_MODE != EDGE_RISE && EDGE_MODE != EDGE_FALL && EDGE_MODE != EDGE_BOTH) begin : g_bad_edge
        $error("multi_spot: EDGE_MODE must be 0, 1 or 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("multi_spot: REPEAT_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        spot_debounce_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DB_CYCLES    (DB_CYCLES),
            .EDGE_MODE    (EDGE_MODE)
`ifdef MULTI_SPOT_AUTOREPEAT_EN
            ,
            .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .spot_in  (spot_in[i]),
            .level_out(level_out[i]),
            .spot_out (spot_out[i])
        );
    end

endmodule

// File: tb/tb_multi_spot.sv
// tb_multi_spot
//   Bench for multi_spot with two instances sharing the inputs: one pulsing
//   on rising edges, one on both edges. A window-based reference model checks
//   every cycle; a vector table and hand-written sequences cover reset,
//   glitch rejection, edge modes and (with MULTI_SPOT_AUTOREPEAT_EN) repeat.
module tb_multi_spot;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int RPT  = 16;
    localparam int HL   = SYNC + DB;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] spot_in = '0;
    logic [N-1:0] level0, spot0, level2, spot2;

    int  assert_count = 0;
    int  fail_count   = 0;
    bit  check_en     = 1'b0;

    always #5 clk = ~clk;

    multi_spot #(
        .N_CH(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .EDGE_MODE(0), .REPEAT_CYCLES(RPT)
    ) dut_rise (
        .clk(clk), .rst(rst), .spot_in(spot_in), .level_out(level0), .spot_out(spot0)
    );

    multi_spot #(
        .N_CH(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .EDGE_MODE(2), .REPEAT_CYCLES(RPT)
    ) dut_both (
        .clk(clk), .rst(rst), .spot_in(spot_in), .level_out(level2), .spot_out(spot2)
    );

    // Reference model: the level flips when the last DB input samples seen
    // through the synchroniser all disagree with it; m_age counts clocks
    // since the debounced rise for the repeat rule.
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_lvl_d = '0;
    int           m_age [N];
    logic         m_hist [N][HL];

    always @(posedge clk or posedge rst) begin
        logic all_diff;
        logic nl;
        if (rst) begin
            m_level <= '0;
            m_lvl_d <= '0;
            for (int ch = 0; ch < N; ch++) begin
                m_age[ch] <= 0;
                for (int j = 0; j < HL; j++) m_hist[ch][j] <= 1'b0;
            end
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                all_diff = 1'b1;
                for (int j = SYNC; j < HL; j++)
                    if (m_hist[ch][j-1] == m_level[ch]) all_diff = 1'b0;
                nl = all_diff ? ~m_level[ch] : m_level[ch];
                m_level[ch] <= nl;
                m_lvl_d[ch] <= m_level[ch];
                m_age[ch]   <= (nl && m_level[ch]) ? m_age[ch] + 1 : 0;
                m_hist[ch][0] <= spot_in[ch];
                for (int j = 1; j < HL; j++) m_hist[ch][j] <= m_hist[ch][j-1];
            end
        end
    end

    function automatic logic [N-1:0] model_spot(input int mode);
        logic [N-1:0] rise, fall, r;
        rise = m_level & ~m_lvl_d;
        fall = ~m_level & m_lvl_d;
        r = (mode == 0) ? rise : (rise | fall);
`ifdef MULTI_SPOT_AUTOREPEAT_EN
        for (int ch = 0; ch < N; ch++)
            if (m_level[ch] && m_age[ch] > 0 && (m_age[ch] % RPT) == 0) r[ch] = 1'b1;
`endif
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_level_rise", 16'(level0), 16'(m_level));
            checkOutput("model_level_both", 16'(level2), 16'(m_level));
            checkOutput("model_spot_rise",  16'(spot0),  16'(model_spot(0)));
            checkOutput("model_spot_both",  16'(spot2),  16'(model_spot(2)));
        end
    end

    // Drive a value for 'hold' cycles and count pulses per channel, one
    // nibble per channel (channel 0 in the low nibble), saturating at 15.
    task automatic applyStimulus(input logic [N-1:0] val, input int hold,
                                 output logic [15:0] cnt0, output logic [15:0] cnt2);
        spot_in = val;
        cnt0 = '0;
        cnt2 = '0;
        repeat (hold) begin
            @(negedge clk);
            for (int ch = 0; ch < N; ch++) begin
                if (spot0[ch] && cnt0[ch*4 +: 4] != 4'hF) cnt0[ch*4 +: 4] = cnt0[ch*4 +: 4] + 4'd1;
                if (spot2[ch] && cnt2[ch*4 +: 4] != 4'hF) cnt2[ch*4 +: 4] = cnt2[ch*4 +: 4] + 4'd1;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] in;
        int           hold;
        logic [N-1:0] lvl;
        logic [15:0]  cnt0;
        logic [15:0]  cnt2;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0]  c0, c2;
        logic [N-1:0] rv;
        int           rem [N];
        bit           found;
        int           off;

        vecs[0] = '{4'b0001, 10, 4'b0001, 16'h0001, 16'h0001};
        vecs[1] = '{4'b0000, 10, 4'b0000, 16'h0000, 16'h0001};
        vecs[2] = '{4'b1001, 10, 4'b1001, 16'h1001, 16'h1001};
        vecs[3] = '{4'b0000, 10, 4'b0000, 16'h0000, 16'h1001};
        vecs[4] = '{4'b0010,  3, 4'b0000, 16'h0000, 16'h0000};
        vecs[5] = '{4'b0000,  8, 4'b0000, 16'h0000, 16'h0000};
        vecs[6] = '{4'b0010,  4, 4'b0000, 16'h0000, 16'h0000};
        vecs[7] = '{4'b0000, 12, 4'b0000, 16'h0010, 16'h0020};

        #1 rst = 1'b1;
        #1;
        checkOutput("reset_level", 16'(level0), 16'h0);
        checkOutput("reset_spot",  16'(spot0),  16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].in, vecs[v].hold, c0, c2);
            checkOutput($sformatf("vec%0d_level", v), 16'(level0), 16'(vecs[v].lvl));
            checkOutput($sformatf("vec%0d_pulses_rise", v), c0, vecs[v].cnt0);
            checkOutput($sformatf("vec%0d_pulses_both", v), c2, vecs[v].cnt2);
        end

        // Reset mid-run with all inputs high, then fresh full latency.
        applyStimulus(4'hF, 10, c0, c2);
        checkOutput("prereset_level", 16'(level0), 16'hF);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_level", 16'(level0), 16'h0);
        checkOutput("async_reset_spot",  16'(spot2),  16'h0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("held_reset_level", 16'(level0), 16'h0);
            checkOutput("held_reset_spot",  16'(spot0),  16'h0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset_spot_e%0d", i), 16'(spot0), (i == 6) ? 16'hF : 16'h0);
        end
        checkOutput("post_reset_level", 16'(level0), 16'hF);
        applyStimulus(4'h0, 12, c0, c2);
        checkOutput("release_pulses_rise", c0, 16'h0000);
        checkOutput("release_pulses_both", c2, 16'h1111);

        // Reset after two counted cycles discards the partial count.
        spot_in = 4'h1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) checkOutput("midcount_level_e5", 16'(level0), 16'h0);
            if (i == 6) checkOutput("midcount_spot_e6", 16'(spot0), 16'h1);
        end
        checkOutput("midcount_level_e6", 16'(level0), 16'h1);
        applyStimulus(4'h0, 12, c0, c2);
        checkOutput("midcount_release_rise", c0, 16'h0000);
        checkOutput("midcount_release_both", c2, 16'h0001);

`ifdef MULTI_SPOT_AUTOREPEAT_EN
        // Hold channel 2: pulses at rise, +16, +32, +48, none after release.
        spot_in = 4'h4;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (spot0[2]) found = 1'b1;
        end
        checkOutput("repeat_rise_seen", 16'(found), 16'h1);
        if (found) begin
            for (off = 1; off <= 52; off++) begin
                @(negedge clk);
                checkOutput($sformatf("repeat_off%0d", off), 16'(spot0), (off % RPT == 0) ? 16'h4 : 16'h0);
            end
            spot_in = 4'h0;
            repeat (25) begin
                @(negedge clk);
                checkOutput("repeat_after_release", 16'(spot0), 16'h0);
            end
        end
`endif

        // Randomised run with one asynchronous reset in the middle.
        rv = '0;
        for (int ch = 0; ch < N; ch++) rem[ch] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (cyc == 400) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            for (int ch = 0; ch < N; ch++) begin
                if (rem[ch] == 0) begin
                    rv[ch]  = 1'($urandom_range(0, 1));
                    rem[ch] = $urandom_range(1, 9);
                end
                rem[ch]--;
            end
            spot_in = rv;
        end
        spot_in = '0;
        repeat (12) @(negedge clk);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
